// File: rtl/conv_block_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// conv_block_sequencer_pkg
// Shared definitions for the convolution block sequencer:
//   - state_t    : main FSM state encoding
//   - PHASE_*    : host-visible phase codes reported on o_phase
//   - GAP_LEN    : number of cycles each GAP state is held
//   - phase_of() : maps a state onto its reported phase
//   - is_busy()  : states in which a sequence is in flight
// ----------------------------------------------------------------------------
package conv_block_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP_L = 3'd2,
        ST_PROC  = 3'd3,
        ST_GAP_P = 3'd4,
        ST_READ  = 3'd5,
        ST_GAP_R = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_LOAD = 2'd1;
    localparam logic [1:0] PHASE_PROC = 2'd2;
    localparam logic [1:0] PHASE_READ = 2'd3;

    // Each GAP state is held this many cycles so the address FSM always
    // sees at least one cycle with its controls low between phases.
    localparam int GAP_LEN   = 2;
    localparam int GAP_CNT_W = 2;

    // A GAP state reports the phase it is closing, so o_phase only moves
    // forward once the next phase's control is actually asserted.
    function automatic logic [1:0] phase_of(input state_t st);
        logic [1:0] ph;
        ph = PHASE_IDLE;
        case (st)
            ST_LOAD, ST_GAP_L: ph = PHASE_LOAD;
            ST_PROC, ST_GAP_P: ph = PHASE_PROC;
            ST_READ, ST_GAP_R: ph = PHASE_READ;
            default:           ph = PHASE_IDLE;
        endcase
        return ph;
    endfunction

    function automatic logic is_busy(input state_t st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

    function automatic logic is_gap(input state_t st);
        return (st == ST_GAP_L) || (st == ST_GAP_P) || (st == ST_GAP_R);
    endfunction

endpackage

// File: rtl/conv_block_sequencer_edge_watch.sv
// ----------------------------------------------------------------------------
// cbs_edge_watch
// Change-block event logic shared by all phases of the sequencer:
//   - rising-edge detector on the change-block level
//   - READ pass counter (READ_PASSES events close a READ phase)
//   - PROC watchdog (fires on the (2^NB_TIMEOUT-1)-th PROC cycle w/o event)
// Ports:
//   clk_i          clock
//   srst_i         synchronous active-high reset
//   clear_i        abort: drops the edge history and both counters
//   change_block_i change-block level from the address FSM
//   pass_en_i      sequencer is in READ (counter held at 0 otherwise)
//   wd_en_i        sequencer is in PROC (watchdog held at 0 otherwise)
//   event_o        rising edge of change_block_i this cycle
//   pass_done_o    this event is the last pass of the READ phase
//   timeout_o      watchdog expires this cycle with no progress
// ----------------------------------------------------------------------------
module cbs_edge_watch
    import conv_block_sequencer_pkg::*;
#(
    parameter int READ_PASSES = 2,
    parameter int NB_TIMEOUT  = 12
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clear_i,
    input  logic change_block_i,
    input  logic pass_en_i,
    input  logic wd_en_i,
    output logic event_o,
    output logic pass_done_o,
    output logic timeout_o
);

    localparam int PASS_W = $clog2(READ_PASSES + 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(READ_PASSES - 1);
    // The counter holds k-1 during the k-th PROC cycle, so the cycle that
    // would bring it to 2^N-1 is the one where it reads 2^N-2.
    localparam logic [NB_TIMEOUT-1:0] WD_LAST =
        NB_TIMEOUT'((64'd1 << NB_TIMEOUT) - 64'd2);

    logic                  prev_q, prev_d;
    logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
    logic [NB_TIMEOUT-1:0] wd_cnt_q, wd_cnt_d;

    assign event_o     = change_block_i & ~prev_q;
    assign pass_done_o = pass_en_i & event_o & (pass_cnt_q == PASS_LAST);
    // An edge on the expiry cycle counts as progress.
    assign timeout_o   = wd_en_i & ~event_o & (wd_cnt_q == WD_LAST);

    always_comb begin
        prev_d     = clear_i ? 1'b0 : change_block_i;

        pass_cnt_d = pass_cnt_q;
        if (clear_i || !pass_en_i || pass_done_o) begin
            pass_cnt_d = '0;
        end else if (event_o) begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
        end

        wd_cnt_d = (clear_i || !wd_en_i) ? '0 : wd_cnt_q + NB_TIMEOUT'(1);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            prev_q     <= 1'b0;
            pass_cnt_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            prev_q     <= prev_d;
            pass_cnt_q <= pass_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

endmodule

// File: rtl/conv_block_sequencer.sv
// ----------------------------------------------------------------------------
// conv_block_sequencer
// Steps the convolution address FSM through nBlocks column-blocks, each as
// LOAD -> GAP -> PROC -> GAP -> READ -> GAP, from a single host run command.
// Ports:
//   i_CLK, i_reset      clock, synchronous active-high reset
//   i_run               start pulse (accepted in IDLE only)
//   i_abort             abort request (wins over everything but reset)
//   i_nBlocks           block count, latched on an accepted run
//   i_imgLength         block length, latched on an accepted run
//   i_hostStrobe        host word strobe (LOAD/READ)
//   i_changeBlock       address-FSM change-block level
//   i_EoP               address-FSM end-of-process (status only)
//   o_load/o_SoP/o_valid/o_fsmReset   controls to the address FSM
//   o_imgLength         latched length forwarded to the address FSM
//   o_blockIdx          current block, 0-based
//   o_phase             0 idle, 1 load, 2 proc, 3 read
//   o_busy/o_done/o_error status
// All outputs are registered.
// ----------------------------------------------------------------------------
module conv_block_sequencer
    import conv_block_sequencer_pkg::*;
#(
    parameter int NB_IMAGE    = 10,
    parameter int NB_BLOCK    = 8,
    parameter int READ_PASSES = 2,
    parameter int NB_TIMEOUT  = 12
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_abort,
    input  logic [NB_BLOCK-1:0] i_nBlocks,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic                i_hostStrobe,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    output logic                o_load,
    output logic                o_SoP,
    output logic                o_valid,
    output logic                o_fsmReset,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [NB_BLOCK-1:0] o_blockIdx,
    output logic [1:0]          o_phase,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    // End-of-process is informational for the host; the sequence advances
    // on change-block edges only.
    logic eop_unused;
    assign eop_unused = i_EoP;

    state_t                 state_q, state_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NB_BLOCK-1:0]    nblocks_q, nblocks_d;
    logic [NB_BLOCK-1:0]    block_idx_q, block_idx_d;
    logic [NB_IMAGE-1:0]    img_len_q, img_len_d;
    logic                   load_q, load_d;
    logic                   sop_q, sop_d;
    logic                   valid_q, valid_d;
    logic                   fsm_reset_q, fsm_reset_d;
    logic [1:0]             phase_q, phase_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic cb_event;
    logic pass_done;
    logic wd_timeout;
    logic abort_req;
    logic gap_last;
    logic last_block;
    logic run_accept;
    logic run_blocks;

    assign abort_req  = i_abort | wd_timeout;
    assign gap_last   = (gap_cnt_q == GAP_CNT_W'(GAP_LEN - 1));
    assign last_block = (block_idx_q == nblocks_q - NB_BLOCK'(1));
    assign run_accept = (state_q == ST_IDLE) & i_run & ~i_abort;
    assign run_blocks = run_accept & (i_nBlocks != '0);

    cbs_edge_watch #(
        .READ_PASSES (READ_PASSES),
        .NB_TIMEOUT  (NB_TIMEOUT)
    ) u_edge_watch (
        .clk_i          (i_CLK),
        .srst_i         (i_reset),
        .clear_i        (abort_req),
        .change_block_i (i_changeBlock),
        .pass_en_i      (state_q == ST_READ),
        .wd_en_i        (state_q == ST_PROC),
        .event_o        (cb_event),
        .pass_done_o    (pass_done),
        .timeout_o      (wd_timeout)
    );

    // ---------------- state register ----------------
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_run) state_d = (i_nBlocks == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (cb_event) state_d = ST_GAP_L;
            ST_GAP_L: if (gap_last) state_d = ST_PROC;
            ST_PROC:  if (cb_event) state_d = ST_GAP_P;
            ST_GAP_P: if (gap_last) state_d = ST_READ;
            ST_READ:  if (pass_done) state_d = ST_GAP_R;
            ST_GAP_R: if (gap_last) state_d = last_block ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_req) begin
            state_d = ST_IDLE;
        end

        gap_cnt_d = '0;
        if (is_gap(state_q) && (state_d == state_q)) begin
            gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
    end

    // ---------------- outputs / latches ----------------
    // Controls are decoded from the next state so they move in the same
    // clock edge as the state itself.
    always_comb begin
        load_d      = (state_d == ST_LOAD);
        sop_d       = (state_d == ST_PROC);
        phase_d     = phase_of(state_d);
        busy_d      = is_busy(state_d);
        valid_d     = i_hostStrobe & ~abort_req &
                      ((state_q == ST_LOAD) | (state_q == ST_READ));
        fsm_reset_d = abort_req;

        nblocks_d   = run_blocks ? i_nBlocks   : nblocks_q;
        img_len_d   = run_blocks ? i_imgLength : img_len_q;

        // Aborts leave the index untouched so the host can see where it stopped.
        block_idx_d = block_idx_q;
        if (run_blocks) begin
            block_idx_d = '0;
        end else if ((state_q == ST_GAP_R) && (state_d == ST_LOAD)) begin
            block_idx_d = block_idx_q + NB_BLOCK'(1);
        end

        done_d = done_q;
        if (run_accept) done_d = 1'b0;
        if (state_d == ST_DONE) done_d = 1'b1;

        error_d = error_q;
        if (run_accept) error_d = 1'b0;
        if (wd_timeout) error_d = 1'b1;
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            load_q      <= 1'b0;
            sop_q       <= 1'b0;
            valid_q     <= 1'b0;
            fsm_reset_q <= 1'b0;
            phase_q     <= PHASE_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            nblocks_q   <= '0;
            block_idx_q <= '0;
            img_len_q   <= '0;
        end else begin
            load_q      <= load_d;
            sop_q       <= sop_d;
            valid_q     <= valid_d;
            fsm_reset_q <= fsm_reset_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            nblocks_q   <= nblocks_d;
            block_idx_q <= block_idx_d;
            img_len_q   <= img_len_d;
        end
    end

    assign o_load      = load_q;
    assign o_SoP       = sop_q;
    assign o_valid     = valid_q;
    assign o_fsmReset  = fsm_reset_q;
    assign o_imgLength = img_len_q;
    assign o_blockIdx  = block_idx_q;
    assign o_phase     = phase_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_conv_block_sequencer.sv
// ----------------------------------------------------------------------------
// tb_conv_block_sequencer
// Directed scenarios followed by random stimulus; a behavioural model of the
// block schedule predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_conv_block_sequencer;

    localparam int TB_NBT      = 4;
    localparam int WD_LIMIT    = (1 << TB_NBT) - 1;
    localparam int PASSES      = 2;

    logic       i_CLK = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_run = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_nBlocks = '0;
    logic [9:0] i_imgLength = '0;
    logic       i_hostStrobe = 1'b0;
    logic       i_changeBlock = 1'b0;
    logic       i_EoP = 1'b0;
    logic       o_load, o_SoP, o_valid, o_fsmReset;
    logic [9:0] o_imgLength;
    logic [7:0] o_blockIdx;
    logic [1:0] o_phase;
    logic       o_busy, o_done, o_error;

    conv_block_sequencer #(
        .NB_IMAGE(10), .NB_BLOCK(8), .READ_PASSES(PASSES), .NB_TIMEOUT(TB_NBT)
    ) dut (
        .i_CLK(i_CLK), .i_reset(i_reset), .i_run(i_run), .i_abort(i_abort),
        .i_nBlocks(i_nBlocks), .i_imgLength(i_imgLength),
        .i_hostStrobe(i_hostStrobe), .i_changeBlock(i_changeBlock), .i_EoP(i_EoP),
        .o_load(o_load), .o_SoP(o_SoP), .o_valid(o_valid), .o_fsmReset(o_fsmReset),
        .o_imgLength(o_imgLength), .o_blockIdx(o_blockIdx), .o_phase(o_phase),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 i_CLK = ~i_CLK;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Schedule positions of one block, plus idle and done.
    localparam int M_IDLE = 0, M_LOAD = 1, M_GAPL = 2, M_PROC = 3,
                   M_GAPP = 4, M_READ = 5, M_GAPR = 6, M_DONE = 7;
    int m_st = M_IDLE, m_gap = 0, m_proc = 0, m_edges = 0, m_nb = 0;
    bit m_prev = 0;
    int e_len = 0, e_idx = 0;
    bit e_valid = 0, e_fsmReset = 0, e_done = 0, e_error = 0;

    task automatic model_step();
        bit ev, tmo, ab;
        if (i_reset) begin
            m_st = M_IDLE; m_gap = 0; m_proc = 0; m_edges = 0; m_nb = 0; m_prev = 0;
            e_len = 0; e_idx = 0; e_valid = 0; e_fsmReset = 0; e_done = 0; e_error = 0;
            return;
        end
        ev     = i_changeBlock && !m_prev;
        m_prev = i_changeBlock;
        tmo    = (m_st == M_PROC) && !ev && (m_proc + 1 == WD_LIMIT);
        ab     = i_abort || tmo;
        e_valid    = i_hostStrobe && (m_st == M_LOAD || m_st == M_READ) && !ab;
        e_fsmReset = ab;
        if (ab) begin
            if (m_st != M_IDLE)
                $display("txn abort watchdog=%0d block=%0d t=%0t", tmo, e_idx, $time);
            m_st = M_IDLE; m_prev = 0; m_edges = 0;
            if (tmo) e_error = 1;
        end else begin
            case (m_st)
                M_IDLE: if (i_run) begin
                    e_error = 0;
                    if (i_nBlocks == 0) m_st = M_DONE;
                    else begin
                        m_nb = i_nBlocks; e_len = i_imgLength; e_idx = 0;
                        e_done = 0; m_st = M_LOAD;
                    end
                end
                M_LOAD: if (ev) begin m_st = M_GAPL; m_gap = 0; end
                M_GAPL: begin
                    m_gap++;
                    if (m_gap == 2) begin m_st = M_PROC; m_proc = 0; end
                end
                M_PROC: if (ev) begin m_st = M_GAPP; m_gap = 0; end
                        else m_proc++;
                M_GAPP: begin
                    m_gap++;
                    if (m_gap == 2) begin m_st = M_READ; m_edges = 0; end
                end
                M_READ: if (ev) begin
                    m_edges++;
                    if (m_edges == PASSES) begin m_edges = 0; m_st = M_GAPR; m_gap = 0; end
                end
                M_GAPR: begin
                    m_gap++;
                    if (m_gap == 2) begin
                        if (e_idx == m_nb - 1) begin
                            m_st = M_DONE;
                            $display("txn run_complete blocks=%0d len=%0d t=%0t", m_nb, e_len, $time);
                        end else begin
                            e_idx++; m_st = M_LOAD;
                        end
                    end
                end
                default: m_st = M_IDLE;
            endcase
        end
        if (m_st == M_DONE) e_done = 1;
    endtask

    function automatic int exp_phase(input int st);
        if (st == M_LOAD || st == M_GAPL) return 1;
        if (st == M_PROC || st == M_GAPP) return 2;
        if (st == M_READ || st == M_GAPR) return 3;
        return 0;
    endfunction

    initial forever begin
        @(posedge i_CLK);
        model_step();
    end

    initial forever begin
        @(negedge i_CLK);
        if (cmp_en) begin
            chk("m_load",     32'(o_load),      32'(m_st == M_LOAD));
            chk("m_sop",      32'(o_SoP),       32'(m_st == M_PROC));
            chk("m_valid",    32'(o_valid),     32'(e_valid));
            chk("m_fsmreset", 32'(o_fsmReset),  32'(e_fsmReset));
            chk("m_imglen",   32'(o_imgLength), 32'(e_len));
            chk("m_blockidx", 32'(o_blockIdx),  32'(e_idx));
            chk("m_phase",    32'(o_phase),     32'(exp_phase(m_st)));
            chk("m_busy",     32'(o_busy),      32'(m_st != M_IDLE && m_st != M_DONE));
            chk("m_done",     32'(o_done),      32'(e_done));
            chk("m_error",    32'(o_error),     32'(e_error));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic run_cmd(input int nb, input int len);
        i_run = 1; i_nBlocks = 8'(nb); i_imgLength = 10'(len);
        tick();
        i_run = 0;
    endtask

    task automatic pulse_cb();
        i_changeBlock = 1; tick();
        i_changeBlock = 0; tick();
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int k = 0; k < 40 && o_phase !== p; k++) tick();
        chk("wait_phase", 32'(o_phase), 32'(p));
    endtask

    task automatic do_block();
        wait_phase(2'd1); pulse_cb();
        wait_phase(2'd2); pulse_cb();
        wait_phase(2'd3); pulse_cb(); pulse_cb();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        i_reset = 1;
        tick();
        cmp_en = 1;
        tick(); tick();
        i_reset = 0;
        chk("rst_phase", 32'(o_phase), 0);
        chk("rst_len",   32'(o_imgLength), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_load",  32'(o_load), 0);
        chk("rst_done",  32'(o_done), 0);
        tick();

        // Single block
        run_cmd(1, 8);
        chk("s1_phase", 32'(o_phase), 1);
        chk("s1_load",  32'(o_load), 1);
        chk("s1_len",   32'(o_imgLength), 8);
        chk("s1_busy",  32'(o_busy), 1);
        for (int i = 0; i < 8; i++) begin
            i_hostStrobe = 1; tick(); chk("s1_valid_hi", 32'(o_valid), 1);
            i_hostStrobe = 0; tick(); chk("s1_valid_lo", 32'(o_valid), 0);
        end
        i_changeBlock = 1; tick(); i_changeBlock = 0;
        chk("s1_load_drop", 32'(o_load), 0);
        tick();
        wait_phase(2'd2);
        chk("s1_sop", 32'(o_SoP), 1);
        pulse_cb();
        wait_phase(2'd3);
        chk("s1_read_sop", 32'(o_SoP), 0);
        for (int i = 0; i < 8; i++) begin
            i_hostStrobe = 1; tick(); i_hostStrobe = 0; tick();
        end
        pulse_cb(); pulse_cb(); tick();
        chk("s1_done", 32'(o_done), 1);
        chk("s1_idx",  32'(o_blockIdx), 0);
        chk("s1_busy_end", 32'(o_busy), 0);
        tick();

        // Three blocks, o_load rises two cycles after GAP_R entry
        run_cmd(3, 16);
        for (int b = 0; b < 3; b++) begin
            wait_phase(2'd1);
            chk("m3_idx", 32'(o_blockIdx), 32'(b));
            pulse_cb();
            wait_phase(2'd2); pulse_cb();
            wait_phase(2'd3); pulse_cb();
            i_changeBlock = 1; tick(); i_changeBlock = 0;
            chk("m3_gapr_load0", 32'(o_load), 0);
            tick();
            chk("m3_gapr_load1", 32'(o_load), 0);
            tick();
            if (b < 2) chk("m3_load_rise", 32'(o_load), 1);
            else       chk("m3_done", 32'(o_done), 1);
        end
        tick();

        // Watchdog
        run_cmd(1, 4);
        wait_phase(2'd1); pulse_cb();
        wait_phase(2'd2);
        n = 0;
        while (o_SoP === 1'b1 && n < 40) begin n++; tick(); end
        chk("wd_cycles",   32'(n), 15);
        chk("wd_error",    32'(o_error), 1);
        chk("wd_fsmreset", 32'(o_fsmReset), 1);
        chk("wd_phase",    32'(o_phase), 0);
        tick();
        chk("wd_fsmreset_end", 32'(o_fsmReset), 0);

        // Abort mid-LOAD of block 1, then restart
        run_cmd(3, 12);
        do_block();
        chk("ab_idx_pre", 32'(o_blockIdx), 1);
        tick();
        i_abort = 1; tick(); i_abort = 0;
        chk("ab_load",     32'(o_load), 0);
        chk("ab_fsmreset", 32'(o_fsmReset), 1);
        chk("ab_error",    32'(o_error), 0);
        chk("ab_idx_held", 32'(o_blockIdx), 1);
        chk("ab_phase",    32'(o_phase), 0);
        tick();
        chk("ab_fsmreset_end", 32'(o_fsmReset), 0);
        run_cmd(1, 7);
        chk("ab_restart_idx", 32'(o_blockIdx), 0);
        do_block();
        chk("ab_restart_done", 32'(o_done), 1);
        tick();

        // Run ignored in PROC; changeBlock held high counts one edge
        run_cmd(1, 20);
        wait_phase(2'd1); pulse_cb();
        wait_phase(2'd2);
        run_cmd(2, 99);
        chk("busy_run_len",   32'(o_imgLength), 20);
        chk("busy_run_phase", 32'(o_phase), 2);
        pulse_cb();
        wait_phase(2'd3);
        i_changeBlock = 1;
        repeat (5) tick();
        i_changeBlock = 0; tick();
        chk("hold_phase", 32'(o_phase), 3);
        chk("hold_done",  32'(o_done), 0);
        i_changeBlock = 1; tick(); i_changeBlock = 0; tick(); tick();
        chk("hold_done_after", 32'(o_done), 1);
        tick();

        // run + abort in the same IDLE cycle
        i_run = 1; i_abort = 1; i_nBlocks = 8'd2; tick();
        i_run = 0; i_abort = 0;
        chk("runab_phase", 32'(o_phase), 0);
        chk("runab_busy",  32'(o_busy), 0);
        chk("runab_fsmreset", 32'(o_fsmReset), 1);
        tick();

        // nBlocks = 0
        run_cmd(0, 5);
        chk("nb0_done", 32'(o_done), 1);
        chk("nb0_busy", 32'(o_busy), 0);
        chk("nb0_load", 32'(o_load), 0);
        tick();
        chk("nb0_phase", 32'(o_phase), 0);

        // Maximum block count runs to completion
        run_cmd(255, 3);
        for (int b = 0; b < 255; b++) begin
            chk("max_idx", 32'(o_blockIdx), 32'(b));
            do_block();
        end
        chk("max_done", 32'(o_done), 1);
        chk("max_idx_last", 32'(o_blockIdx), 254);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            i_reset      = ($urandom_range(0, 1499) == 0);
            i_abort      = ($urandom_range(0, 299) == 0);
            i_run        = ($urandom_range(0, 15) == 0);
            i_nBlocks    = 8'($urandom_range(0, 3));
            i_imgLength  = 10'($urandom);
            i_hostStrobe = 1'($urandom_range(0, 1));
            i_EoP        = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) i_changeBlock = ~i_changeBlock;
            tick();
        end
        i_reset = 0; i_abort = 0; i_run = 0; i_hostStrobe = 0; i_changeBlock = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_block_sequencer.md
# conv_block_sequencer

Block-level scheduler for the convolution address FSM. It takes one host run command and steps through a sequence of image column-blocks. Each block goes through three phases: LOAD (host writes pixels), PROC (convolver streams the block), READ (host reads results). The block drives the address FSM's load/start-of-process/valid controls and watches its change-block and end-of-process flags. It sits between the host GPIO register interface and the address FSM.

## Interface
- NB_IMAGE, 10, width of image length
- NB_BLOCK, 8, width of block count and block index
- READ_PASSES, 2, change-block events that end a READ phase
- NB_TIMEOUT, 12, width of PROC watchdog counter; timeout at 2^NB_TIMEOUT-1 cycles
- Reset: one clock; reset is synchronous and active-high.
- i_CLK  in  1  sole clock
- i_reset  in  1  synchronous active-high reset
- i_run  in  1  start-sequence pulse; sampled only in IDLE
- i_abort  in  1  abort request; highest priority after reset
- i_nBlocks  in  NB_BLOCK  number of blocks; latched on accepted i_run
- i_imgLength  in  NB_IMAGE  block length; latched on accepted i_run
- i_hostStrobe  in  1  host word strobe in LOAD/READ, one word per high level
- i_changeBlock  in  1  address-FSM change-block level
- i_EoP  in  1  address-FSM end-of-process flag; status only
- o_load  out  1  load request to address FSM
- o_SoP  out  1  start-of-process to address FSM
- o_valid  out  1  word valid to address FSM
- o_fsmReset  out  1  one-cycle reset pulse to address FSM
- o_imgLength  out  NB_IMAGE  latched length forwarded to address FSM
- o_blockIdx  out  NB_BLOCK  current block, 0-based
- o_phase  out  2  0 idle, 1 load, 2 proc, 3 read
- o_busy / o_done / o_error  out  1 each  status

## Operation
- States: IDLE, LOAD, GAP_L, PROC, GAP_P, READ, GAP_R, DONE.
- IDLE: all controls low.
  - i_run with i_nBlocks≠0: latch i_nBlocks and i_imgLength, blockIdx←0, clear o_done and o_error, go to LOAD.
  - i_run with i_nBlocks=0: go straight to DONE.
- LOAD: o_load=1, o_valid=registered i_hostStrobe. A rising edge of i_changeBlock goes to GAP_L.
- GAP_L: o_load=0 for 2 cycles, then PROC.
- PROC: o_SoP=1, o_valid=0, watchdog counts every cycle.
  - A rising edge of i_changeBlock goes to GAP_P.
  - Watchdog reaching its maximum sets o_error and triggers the abort path.
- GAP_P: o_SoP=0 for 2 cycles, then READ. The address FSM enters readback by itself while load and SoP are both low.
- READ: o_load=0, o_SoP=0, o_valid=registered i_hostStrobe.
  - Count rising edges of i_changeBlock.
  - On the READ_PASSES-th edge, go to GAP_R and clear the pass count.
- GAP_R: 2 cycles.
  - If blockIdx = nBlocks-1, go to DONE.
  - Otherwise blockIdx+1 and go to LOAD.
- DONE: o_done=1 (sticky until next accepted i_run), o_busy=0, then IDLE on the next cycle.
- Abort (i_abort, or watchdog):
  - Controls go low the next cycle and o_fsmReset pulses for 1 cycle.
  - State returns to IDLE; blockIdx is held for debug.
  - o_error=1 only on watchdog timeout.
- Edge detect: i_changeBlock is a level. An event is i_changeBlock & ~prev, with prev cleared on reset and abort.
- o_busy=1 in every state except IDLE and DONE.
- i_run while busy is ignored. i_run and i_abort in the same IDLE cycle: abort wins and the run is not accepted.
- i_hostStrobe outside LOAD/READ is ignored; o_valid stays 0.

## Timing
- Reset values: all outputs 0, o_imgLength=0, state IDLE, counters 0. An i_reset mid-sequence behaves the same; there is no o_fsmReset pulse because the address FSM shares i_reset.
- All outputs are registered.
- o_load, o_SoP and o_phase update 1 cycle after the state transition condition.
- o_valid lags i_hostStrobe by 1 cycle. The host must hold the strobe low ≥1 cycle between words because the address FSM is edge-triggered.
- Change-block edge to dropping o_load/o_SoP: 1 cycle.
- Each GAP state holds 2 cycles, guaranteeing ≥1 idle cycle seen by the address FSM.
- Watchdog clears on entry to PROC; timeout after 2^NB_TIMEOUT-1 PROC cycles with no edge.
- An edge on the same cycle as the watchdog maximum counts as progress; no error.
- blockIdx wrap is impossible: the last block is nBlocks-1 ≤ 2^NB_BLOCK-2 when nBlocks ≤ 2^NB_BLOCK-1. nBlocks=2^NB_BLOCK-1 runs fully.

## Structure
- Shared package: state encoding constants, phase codes (0–3), GAP length (2).
- Sub-module cbs_edge_watch: change-block rising-edge detector plus READ pass counter plus PROC watchdog, with clear/enable from the main FSM.
- Main FSM and latches stay in conv_block_sequencer.

## Test plan
- Single block: nBlocks=1, imgLength=8, 8 strobes, changeBlock pulse per phase (1 in LOAD, 1 in PROC, 2 in READ) -> phases 1,2,3, o_done=1, blockIdx=0.
- Three blocks -> blockIdx steps 0,1,2. o_load rises 2 cycles after each GAP_R entry. o_done after third READ.
- PROC watchdog, NB_TIMEOUT=4, changeBlock held low -> o_error=1 after 15 PROC cycles, o_fsmReset 1-cycle pulse, IDLE.
- i_abort mid-LOAD at block 1 -> controls 0 next cycle, o_fsmReset pulse, o_error=0, blockIdx=1 held. New i_run restarts at block 0.
- changeBlock held high 5 cycles in READ -> counts 1 edge only. Phase ends only after second edge.
- i_run during PROC ignored. i_run+i_abort same IDLE cycle -> stays IDLE. nBlocks=0 -> DONE next cycle, o_load never asserted.
